// File: rtl/cluster_bus_txn_regulator_if.sv
// AW/AR handshake bundle for one crossbar slave port, with the B/R handshake
// signals carried along so the regulator can observe credit returns.
interface cluster_bus_txn_regulator_if;
    logic aw_valid;
    logic aw_ready;
    logic ar_valid;
    logic ar_ready;
    logic b_valid;
    logic b_ready;
    logic r_valid;
    logic r_ready;
    logic r_last;

    // Upstream-facing side: the regulator accepts AW/AR and only watches B/R.
    modport slave (
        input  aw_valid, ar_valid,
        input  b_valid, b_ready, r_valid, r_ready, r_last,
        output aw_ready, ar_ready
    );

    // Crossbar-facing side: the regulator forwards AW/AR valids.
    modport master (
        output aw_valid, ar_valid,
        input  aw_ready, ar_ready
    );
endinterface

// File: rtl/cluster_bus_txn_regulator.sv
// Caps outstanding AW/AR transactions on one crossbar slave port and drains /
// isolates the port on request; payload channels bypass this block entirely.
module cluster_bus_txn_regulator #(
    parameter int MAX_WR_TXNS = 8,
    parameter int MAX_RD_TXNS = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               isolate_i,
    output logic                               isolated_o,
    output logic                               busy_o,
    output logic                               err_o,
    cluster_bus_txn_regulator_if.slave         slv,
    cluster_bus_txn_regulator_if.master        mst
);

    localparam int WR_CW = $clog2(MAX_WR_TXNS + 1);
    localparam int RD_CW = $clog2(MAX_RD_TXNS + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ISOLATED
    } state_t;

    state_t             state_q, state_d;
    logic [WR_CW-1:0]   wr_cnt_q;
    logic [RD_CW-1:0]   rd_cnt_q;
    logic               aw_pend_q, ar_pend_q;
    logic               err_q;

    logic b_hs, r_last_hs, aw_hs, ar_hs;
    logic aw_open, ar_open;
    logic port_idle;

    assign b_hs      = slv.b_valid & slv.b_ready;
    assign r_last_hs = slv.r_valid & slv.r_ready & slv.r_last;

    // A pending valid is never withdrawn; otherwise a same-cycle credit return
    // lets a new request through even when the table is full.
    assign aw_open = aw_pend_q |
                     (((wr_cnt_q < WR_CW'(MAX_WR_TXNS)) | b_hs) & (state_q == ST_RUN));
    assign ar_open = ar_pend_q |
                     (((rd_cnt_q < RD_CW'(MAX_RD_TXNS)) | r_last_hs) & (state_q == ST_RUN));

    assign mst.aw_valid = slv.aw_valid & aw_open;
    assign slv.aw_ready = mst.aw_ready & aw_open;
    assign mst.ar_valid = slv.ar_valid & ar_open;
    assign slv.ar_ready = mst.ar_ready & ar_open;

    assign aw_hs = mst.aw_valid & mst.aw_ready;
    assign ar_hs = mst.ar_valid & mst.ar_ready;

    assign port_idle  = (wr_cnt_q == '0) & (rd_cnt_q == '0) & ~aw_pend_q & ~ar_pend_q;
    assign isolated_o = (state_q == ST_ISOLATED);
    assign busy_o     = ~port_idle;
    assign err_o      = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (isolate_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!isolate_i)     state_d = ST_RUN;
                else if (port_idle) state_d = ST_ISOLATED;
            end
            ST_ISOLATED: begin
                if (!isolate_i) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Counters saturate at zero on a spurious credit return and flag it stickily.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            aw_pend_q <= 1'b0;
            ar_pend_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (aw_hs && !b_hs)
                wr_cnt_q <= wr_cnt_q + WR_CW'(1);
            else if (b_hs && !aw_hs && (wr_cnt_q != '0))
                wr_cnt_q <= wr_cnt_q - WR_CW'(1);

            if (ar_hs && !r_last_hs)
                rd_cnt_q <= rd_cnt_q + RD_CW'(1);
            else if (r_last_hs && !ar_hs && (rd_cnt_q != '0))
                rd_cnt_q <= rd_cnt_q - RD_CW'(1);

            if ((b_hs && (wr_cnt_q == '0)) || (r_last_hs && (rd_cnt_q == '0)))
                err_q <= 1'b1;

            if (aw_hs)                            aw_pend_q <= 1'b0;
            else if (mst.aw_valid && !mst.aw_ready) aw_pend_q <= 1'b1;

            if (ar_hs)                            ar_pend_q <= 1'b0;
            else if (mst.ar_valid && !mst.ar_ready) ar_pend_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cluster_bus_txn_regulator.sv
// Directed bench for cluster_bus_txn_regulator with a 2-deep write table and a
// 4-deep read table; expected values are worked out by hand per step.
module tb_cluster_bus_txn_regulator;

    logic clk = 1'b0;
    logic rst_n;
    logic isolate;
    logic isolated, busy, err;
    int   checks = 0;
    int   passes = 0;
    int   exp_rd;

    cluster_bus_txn_regulator_if slv_bus ();
    cluster_bus_txn_regulator_if mst_bus ();

    cluster_bus_txn_regulator #(
        .MAX_WR_TXNS(2),
        .MAX_RD_TXNS(4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .isolate_i  (isolate),
        .isolated_o (isolated),
        .busy_o     (busy),
        .err_o      (err),
        .slv        (slv_bus),
        .mst        (mst_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_output(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    endtask

    initial begin
        rst_n = 1'b0;
        isolate = 1'b0;
        slv_bus.aw_valid = 1'b0;
        slv_bus.ar_valid = 1'b0;
        slv_bus.b_valid  = 1'b0;
        slv_bus.b_ready  = 1'b0;
        slv_bus.r_valid  = 1'b0;
        slv_bus.r_ready  = 1'b0;
        slv_bus.r_last   = 1'b0;
        mst_bus.aw_ready = 1'b0;
        mst_bus.ar_ready = 1'b0;
        #1;
        check_output("rst_isolated", isolated, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_err", err, 1'b0);
        check_output("rst_mst_aw_valid", mst_bus.aw_valid, 1'b0);
        check_output("rst_slv_ar_ready", slv_bus.ar_ready, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Write limit of 2 with same-cycle credit return.
        slv_bus.aw_valid = 1'b1;
        mst_bus.aw_ready = 1'b1;
        #1;
        check_output("wr_aw1_valid", mst_bus.aw_valid, 1'b1);
        check_output("wr_aw1_ready", slv_bus.aw_ready, 1'b1);
        tick();
        check_output("wr_aw2_ready", slv_bus.aw_ready, 1'b1);
        check_output("wr_busy", busy, 1'b1);
        tick();
        check_output("wr_full_ready", slv_bus.aw_ready, 1'b0);
        check_output("wr_full_valid", mst_bus.aw_valid, 1'b0);
        slv_bus.b_valid = 1'b1;
        slv_bus.b_ready = 1'b1;
        #1;
        check_output("wr_credit_ready", slv_bus.aw_ready, 1'b1);
        check_output("wr_credit_valid", mst_bus.aw_valid, 1'b1);
        tick();
        slv_bus.b_valid = 1'b0;
        #1;
        check_output("wr_still_full", slv_bus.aw_ready, 1'b0);
        slv_bus.aw_valid = 1'b0;
        slv_bus.b_valid = 1'b1;
        tick();
        check_output("wr_one_left_busy", busy, 1'b1);
        tick();
        slv_bus.b_valid = 1'b0;
        #1;
        check_output("wr_drained_busy", busy, 1'b0);
        check_output("wr_no_err", err, 1'b0);

        // Four reads, then four 3-beat bursts; only last beats return credit.
        slv_bus.ar_valid = 1'b1;
        mst_bus.ar_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        slv_bus.ar_valid = 1'b0;
        #1;
        check_output("rd_full_ready", slv_bus.ar_ready, 1'b0);
        exp_rd = 4;
        slv_bus.r_ready = 1'b1;
        for (int beat = 1; beat <= 12; beat++) begin
            slv_bus.r_valid = 1'b1;
            slv_bus.r_last  = (beat % 3 == 0);
            tick();
            if (beat % 3 == 0) exp_rd--;
            slv_bus.r_valid = 1'b0;
            slv_bus.r_last  = 1'b0;
            #1;
            check_output($sformatf("rd_beat%0d_busy", beat), busy, exp_rd != 0);
            check_output($sformatf("rd_beat%0d_ready", beat), slv_bus.ar_ready, exp_rd < 4);
        end
        slv_bus.r_ready = 1'b0;

        // Stalled AW must stay presented through the drain, then isolate.
        tick();
        slv_bus.aw_valid = 1'b1;
        mst_bus.aw_ready = 1'b0;
        #1;
        check_output("drn_aw_valid0", mst_bus.aw_valid, 1'b1);
        check_output("drn_aw_ready0", slv_bus.aw_ready, 1'b0);
        isolate = 1'b1;
        tick();
        check_output("drn_aw_valid1", mst_bus.aw_valid, 1'b1);
        tick();
        check_output("drn_aw_valid2", mst_bus.aw_valid, 1'b1);
        check_output("drn_not_isolated", isolated, 1'b0);
        mst_bus.aw_ready = 1'b1;
        #1;
        check_output("drn_aw_accept", slv_bus.aw_ready, 1'b1);
        tick();
        #1;
        check_output("drn_new_aw_blocked", mst_bus.aw_valid, 1'b0);
        check_output("drn_busy", busy, 1'b1);
        slv_bus.aw_valid = 1'b0;
        slv_bus.b_valid = 1'b1;
        slv_bus.b_ready = 1'b1;
        tick();
        slv_bus.b_valid = 1'b0;
        tick();
        check_output("drn_isolated", isolated, 1'b1);
        slv_bus.aw_valid = 1'b1;
        #1;
        check_output("iso_aw_ready", slv_bus.aw_ready, 1'b0);
        check_output("iso_aw_valid", mst_bus.aw_valid, 1'b0);
        slv_bus.aw_valid = 1'b0;
        isolate = 1'b0;
        tick();
        check_output("iso_release", isolated, 1'b0);

        // One-cycle isolate pulse on an idle port.
        isolate = 1'b1;
        tick();
        isolate = 1'b0;
        slv_bus.ar_valid = 1'b1;
        #1;
        check_output("pulse_drain_blocks_ar", slv_bus.ar_ready, 1'b0);
        tick();
        check_output("pulse_run_ar_ready", slv_bus.ar_ready, 1'b1);
        check_output("pulse_not_isolated", isolated, 1'b0);
        tick();
        slv_bus.ar_valid = 1'b0;
        #1;
        check_output("pulse_ar_taken", busy, 1'b1);
        slv_bus.r_valid = 1'b1;
        slv_bus.r_ready = 1'b1;
        slv_bus.r_last  = 1'b1;
        tick();
        slv_bus.r_valid = 1'b0;
        #1;
        check_output("pulse_idle", busy, 1'b0);
        check_output("pulse_no_err", err, 1'b0);

        // Spurious B at zero: sticky error, counter must not wrap.
        slv_bus.b_valid = 1'b1;
        tick();
        slv_bus.b_valid = 1'b0;
        #1;
        check_output("spur_err", err, 1'b1);
        check_output("spur_busy", busy, 1'b0);
        slv_bus.aw_valid = 1'b1;
        #1;
        check_output("spur_aw_ready", slv_bus.aw_ready, 1'b1);
        tick();
        tick();
        #1;
        check_output("spur_limit_after", slv_bus.aw_ready, 1'b0);
        check_output("spur_err_sticky", err, 1'b1);
        slv_bus.aw_valid = 1'b0;

        // Async reset with outstanding traffic while draining.
        slv_bus.ar_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        slv_bus.ar_valid = 1'b0;
        isolate = 1'b1;
        tick();
        check_output("prerst_busy", busy, 1'b1);
        check_output("prerst_drain_blocks", slv_bus.ar_ready, 1'b0);
        rst_n = 1'b0;
        slv_bus.aw_valid = 1'b1;
        #1;
        check_output("arst_busy", busy, 1'b0);
        check_output("arst_err", err, 1'b0);
        check_output("arst_isolated", isolated, 1'b0);
        check_output("arst_run_aw_valid", mst_bus.aw_valid, 1'b1);
        slv_bus.aw_valid = 1'b0;
        isolate = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_output("post_rst_isolated", isolated, 1'b0);
        slv_bus.aw_valid = 1'b1;
        #1;
        check_output("post_rst_aw_ready", slv_bus.aw_ready, 1'b1);
        slv_bus.aw_valid = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
